// File: rtl/fixedpoint_formatter_pipe_if.sv
// Purpose : bundles the input beat, output beat and sticky-overflow signals of the formatter.
// Latency : none, wiring only.
// Backpr. : carries valid/ready for both sides; slave is the formatter, master is its environment.
interface fixedpoint_formatter_pipe_if #(
  parameter int LANES = 4,
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
);
  logic                   valid_i;
  logic                   ready_o;
  logic [LANES*IN_W-1:0]  data_i;
  logic [1:0]             mode_i;
  logic                   sat_en_i;
  logic                   valid_o;
  logic                   ready_i;
  logic [LANES*OUT_W-1:0] data_o;
  logic [LANES-1:0]       ovf_o;
  logic [LANES-1:0]       sticky_ovf_o;
  logic                   clr_i;

  modport slave (
    input  valid_i, data_i, mode_i, sat_en_i, ready_i, clr_i,
    output ready_o, valid_o, data_o, ovf_o, sticky_ovf_o
  );

  modport master (
    output valid_i, data_i, mode_i, sat_en_i, ready_i, clr_i,
    input  ready_o, valid_o, data_o, ovf_o, sticky_ovf_o
  );
endinterface

// File: rtl/fixedpoint_formatter_pipe.sv
// Purpose : multi-lane signed fixed-point narrowing: round away SHIFT LSBs, then saturate or wrap.
// Latency : 2 cycles input transfer to valid_o, 1 beat/cycle throughput.
// Backpr. : two-stage skid-free pipeline; ready_o drops only when both stages hold a beat and ready_i=0.
module fixedpoint_formatter_pipe #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 16,
  parameter int LANES = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  fixedpoint_formatter_pipe_if.slave bus
);

  // Rounded value keeps one extra bit above the shifted word so the +1 never wraps.
  localparam int RW = IN_W - SHIFT + 1;
  localparam logic [SHIFT-1:0] HALF = SHIFT'(1) << (SHIFT - 1);

  logic                            w_en1;
  logic                            w_en2;
  logic                            w_oxfer;
  logic [LANES-1:0][RW-1:0]        w_round;
  logic [LANES-1:0][OUT_W-1:0]     w_fmt;
  logic [LANES-1:0]                w_ovf;

  logic                            r_s1_vld;
  logic                            r_s1_sat;
  logic [LANES-1:0][RW-1:0]        r_s1_r;
  logic                            r_vld;
  logic [LANES-1:0][OUT_W-1:0]     r_dat;
  logic [LANES-1:0]                r_ovf;
  logic [LANES-1:0]                r_sticky;

  // Output stage advances when empty or drained; stage 1 advances when empty or stage 2 moves.
  assign w_en2   = ~r_vld | bus.ready_i;
  assign w_en1   = ~r_s1_vld | w_en2;
  assign w_oxfer = r_vld & bus.ready_i;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IN_W-1:0]      w_x;
    logic [RW-1:0]        w_q;
    logic [SHIFT-1:0]     w_f;
    logic                 w_inc;
    logic [RW-OUT_W:0]    w_top;

    assign w_x = bus.data_i[k*IN_W +: IN_W];
    // Arithmetic shift: sign bit duplicated into the extra headroom bit.
    assign w_q = {w_x[IN_W-1], w_x[IN_W-1:SHIFT]};
    assign w_f = w_x[SHIFT-1:0];

    // Rounding increment chosen by the beat's mode; reserved code falls back to floor.
    always_comb begin
      case (bus.mode_i)
        2'b01:   w_inc = (w_f >= HALF);
        2'b10:   w_inc = (w_f > HALF) | ((w_f == HALF) & w_q[0]);
        default: w_inc = 1'b0;
      endcase
    end

    assign w_round[k] = w_q + RW'(w_inc);

    // In range only if every bit from the OUT_W sign position upward agrees.
    assign w_top    = r_s1_r[k][RW-1:OUT_W-1];
    assign w_ovf[k] = ~((&w_top) | ~(|w_top));
    assign w_fmt[k] = (w_ovf[k] & r_s1_sat)
                    ? {r_s1_r[k][RW-1], {(OUT_W-1){~r_s1_r[k][RW-1]}}}
                    : r_s1_r[k][OUT_W-1:0];
  end

  // Stage 1: capture the rounded lanes and the saturate flag that travels with the beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_vld <= 1'b0;
      r_s1_sat <= 1'b0;
      r_s1_r   <= '0;
    end else if (w_en1) begin
      r_s1_vld <= bus.valid_i;
      if (bus.valid_i) begin
        r_s1_r   <= w_round;
        r_s1_sat <= bus.sat_en_i;
      end
    end
  end

  // Stage 2: range-checked result; held untouched while stalled downstream.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld <= 1'b0;
      r_dat <= '0;
      r_ovf <= '0;
    end else if (w_en2) begin
      r_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_dat <= w_fmt;
        r_ovf <= w_ovf;
      end
    end
  end

  // Sticky overflow: a set on an output transfer overrides a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (bus.clr_i ? '0 : r_sticky) | ({LANES{w_oxfer}} & r_ovf);
    end
  end

  assign bus.ready_o      = w_en1;
  assign bus.valid_o      = r_vld;
  assign bus.data_o       = r_dat;
  assign bus.ovf_o        = r_ovf;
  assign bus.sticky_ovf_o = r_sticky;

endmodule

// File: tb/tb_fixedpoint_formatter_pipe.sv
// Purpose : randomized and directed checking of the formatter against an arithmetic reference.
// Latency : expects 2-cycle transfer-to-valid when downstream is always ready.
// Backpr. : drives ready_i always-high, 1-0-0 pattern, random and held-low.
module tb_fixedpoint_formatter_pipe;
  localparam int LANES = 4;
  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int SHIFT = 16;

  logic clk_i;
  logic rst_i;

  fixedpoint_formatter_pipe_if #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  fixedpoint_formatter_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .LANES(LANES)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [LANES*OUT_W-1:0] dat;
    logic [LANES-1:0]       ovf;
    int                     cyc;
  } exp_t;

  int               n_tests = 0;
  int               n_fail  = 0;
  int               cyc     = 0;
  int               rdy_mode = 0;
  int               rdy_ph  = 0;
  bit               lat_mode = 0;
  bit               seen_rdy_lo = 0;
  exp_t             sb[$];
  logic [LANES-1:0] sticky_exp = '0;
  exp_t             m_front;
  exp_t             m_new;
  bit               m_out_x;
  bit               m_have;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One lane from first principles: floor-divide, choose increment, clamp or wrap.
  function automatic logic [OUT_W-1:0] ref_lane(input logic [IN_W-1:0] x, input logic [1:0] mode,
                                                 input logic sat, output logic ovf);
    longint     xs, scale, q, f, r, lim_hi, lim_lo;
    logic [63:0] rb;
    scale  = longint'(1) << SHIFT;
    xs     = longint'($signed(x));
    q      = xs >>> SHIFT;
    f      = xs - q * scale;
    r      = q;
    if (mode == 2'b01 && 2 * f >= scale) r = q + 1;
    else if (mode == 2'b10 && (2 * f > scale || (2 * f == scale && (q % 2) != 0))) r = q + 1;
    lim_hi = (longint'(1) << (OUT_W - 1)) - 1;
    lim_lo = -(longint'(1) << (OUT_W - 1));
    ovf    = (r > lim_hi) || (r < lim_lo);
    if (ovf && sat) r = (r > 0) ? lim_hi : lim_lo;
    rb = r;
    return rb[OUT_W-1:0];
  endfunction

  function automatic exp_t model(input logic [LANES*IN_W-1:0] d, input logic [1:0] m, input logic s);
    exp_t e;
    logic o;
    for (int k = 0; k < LANES; k++) begin
      e.dat[k*OUT_W +: OUT_W] = ref_lane(d[k*IN_W +: IN_W], m, s, o);
      e.ovf[k] = o;
    end
    e.cyc = 0;
    return e;
  endfunction

  function automatic logic [IN_W-1:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(3))
      0:       return w;
      1:       return {{8{w[23]}}, w[23:0]};
      2:       return {{9{w[22]}}, w[22:16], 16'h8000};
      default: return {w[31:16], 16'h8000};
    endcase
  endfunction

  always @(posedge clk_i) cyc++;

  // Scoreboard: sampled mid-cycle, models the handshake and sticky flags at the next edge.
  always @(negedge clk_i) begin
    if (rst_i) begin
      sb.delete();
      sticky_exp = '0;
    end else begin
      if (!bus.ready_o) seen_rdy_lo = 1;
      chk("ready_o", bus.ready_o, !(sb.size() == 2 && !bus.ready_i));
      chk("sticky_ovf_o", bus.sticky_ovf_o, sticky_exp);
      m_have  = (sb.size() > 0);
      m_out_x = bus.valid_o && bus.ready_i;
      if (m_have) m_front = sb[0];
      if (bus.valid_o) begin
        if (!m_have) chk("spurious_valid_o", bus.valid_o, 0);
        else begin
          chk("data_o", bus.data_o, m_front.dat);
          chk("ovf_o", bus.ovf_o, m_front.ovf);
          if (lat_mode && bus.ready_i) chk("latency", cyc - m_front.cyc, 2);
        end
      end
      if (bus.clr_i) sticky_exp = '0;
      if (m_out_x && m_have) begin
        sticky_exp = sticky_exp | m_front.ovf;
        void'(sb.pop_front());
      end
      if (bus.valid_i && bus.ready_o) begin
        m_new     = model(bus.data_i, bus.mode_i, bus.sat_en_i);
        m_new.cyc = cyc;
        sb.push_back(m_new);
      end
    end
  end

  // Downstream ready generator.
  initial begin
    bus.ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      case (rdy_mode)
        0: bus.ready_i = 1'b1;
        1: begin
          bus.ready_i = (rdy_ph == 0);
          rdy_ph      = (rdy_ph + 1) % 3;
        end
        2: bus.ready_i = 1'($urandom_range(1));
        default: bus.ready_i = 1'b0;
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send(input logic [LANES*IN_W-1:0] d, input logic [1:0] m, input logic s,
                      output int waits);
    bit acc;
    waits        = 0;
    acc          = 0;
    bus.valid_i  = 1'b1;
    bus.data_i   = d;
    bus.mode_i   = m;
    bus.sat_en_i = s;
    while (!acc) begin
      @(negedge clk_i);
      acc = bus.ready_o;
      @(posedge clk_i);
      #1;
      if (!acc) begin
        waits++;
        if (waits > 100) begin
          chk("send_timeout", 64'(waits), 0);
          break;
        end
      end
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 0);
  endtask

  // Single beat with ready_i held high: result must be on the output one edge after acceptance.
  task automatic drt(input string tag, input logic [LANES*IN_W-1:0] d, input logic [1:0] m,
                     input logic s, input logic [LANES*OUT_W-1:0] ed, input logic [LANES-1:0] eo);
    int w;
    send(d, m, s, w);
    tick(1);
    chk({tag, "_vld"}, bus.valid_o, 1);
    chk({tag, "_dat"}, bus.data_o, ed);
    chk({tag, "_ovf"}, bus.ovf_o, eo);
    tick(1);
  endtask

  initial begin
    int w;
    logic [LANES*IN_W-1:0] d;
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [LANES*IN_W-1:0] d;
    rst_i        = 1'b1;
    bus.valid_i  = 1'b0;
    bus.data_i   = '0;
    bus.mode_i   = 2'b00;
    bus.sat_en_i = 1'b0;
    bus.clr_i    = 1'b0;
    tick(3);
    rst_i = 1'b0;
    chk("rst_valid_o", bus.valid_o, 0);
    chk("rst_data_o", bus.data_o, 0);
    chk("rst_ovf_o", bus.ovf_o, 0);
    chk("rst_sticky", bus.sticky_ovf_o, 0);
    chk("rst_ready_o", bus.ready_o, 1);

    lat_mode = 1;
    drt("trunc",    {96'h0, 32'h0103DE42}, 2'b00, 1'b1, {48'h0, 16'h0103}, 4'b0000);
    drt("halfup",   {96'h0, 32'h0103DE42}, 2'b01, 1'b1, {48'h0, 16'h0104}, 4'b0000);
    drt("halfeven", {96'h0, 32'h0103DE42}, 2'b10, 1'b1, {48'h0, 16'h0104}, 4'b0000);
    drt("mode11",   {96'h0, 32'h0103DE42}, 2'b11, 1'b1, {48'h0, 16'h0103}, 4'b0000);
    drt("tie_up",   {96'h0, 32'h00028000}, 2'b01, 1'b1, {48'h0, 16'h0003}, 4'b0000);
    drt("tie_even", {96'h0, 32'h00028000}, 2'b10, 1'b1, {48'h0, 16'h0002}, 4'b0000);
    drt("neg_trunc",{96'h0, 32'hFFFF8000}, 2'b00, 1'b1, {48'h0, 16'hFFFF}, 4'b0000);
    drt("neg_up",   {96'h0, 32'hFFFF8000}, 2'b01, 1'b1, {48'h0, 16'h0000}, 4'b0000);
    drt("neg_even", {96'h0, 32'hFFFF8000}, 2'b10, 1'b1, {48'h0, 16'h0000}, 4'b0000);
    drt("ovf_sat",  {96'h0, 32'h7FFF8000}, 2'b01, 1'b1, {48'h0, 16'h7FFF}, 4'b0001);
    drt("ovf_wrap", {96'h0, 32'h7FFF8000}, 2'b01, 1'b0, {48'h0, 16'h8000}, 4'b0001);
    drt("min_sat",  {96'h0, 32'h80000000}, 2'b00, 1'b1, {48'h0, 16'h8000}, 4'b0000);
    drt("mixed",    {32'h0, 32'hFFFF8000, 32'h7FFF8000, 32'h0103DE42}, 2'b01, 1'b1,
                    {16'h0, 16'h0, 16'h7FFF, 16'h0104}, 4'b0010);

    chk("sticky_set", bus.sticky_ovf_o, 4'b0011);
    tick(2);
    chk("sticky_hold", bus.sticky_ovf_o, 4'b0011);
    bus.clr_i = 1'b1;
    tick(1);
    bus.clr_i = 1'b0;
    chk("sticky_clr", bus.sticky_ovf_o, 4'b0000);
    send({96'h0, 32'h7FFF8000}, 2'b01, 1'b1, w);
    tick(1);
    bus.clr_i = 1'b1;
    tick(1);
    bus.clr_i = 1'b0;
    chk("sticky_set_wins", bus.sticky_ovf_o, 4'b0001);

    // Back-to-back beats with full downstream readiness: one accept per cycle.
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < LANES; k++) d[k*IN_W +: IN_W] = rnd_word();
      send(d, 2'($urandom_range(3)), 1'($urandom_range(1)), w);
      chk("throughput", 64'(w), 0);
    end
    drain();

    // Incrementing stream against a 1,0,0 ready pattern.
    lat_mode    = 0;
    seen_rdy_lo = 0;
    rdy_ph      = 0;
    rdy_mode    = 1;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < LANES; k++) d[k*IN_W +: IN_W] = (32'(i) << 16) + 32'(k * 16'h1000);
      send(d, 2'b00, 1'b1, w);
    end
    drain();
    chk("bp_ready_dropped", seen_rdy_lo, 1);

    // Random traffic, random gaps, random clears, random downstream readiness.
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < LANES; k++) d[k*IN_W +: IN_W] = rnd_word();
      bus.clr_i = ($urandom_range(9) == 0);
      send(d, 2'($urandom_range(3)), 1'($urandom_range(1)), w);
      bus.clr_i = 1'b0;
      tick($urandom_range(2));
    end
    drain();

    // Reset with both stages occupied.
    rdy_mode = 0;
    tick(2);
    drt("pre_rst_ovf", {96'h0, 32'h7FFF8000}, 2'b01, 1'b1, {48'h0, 16'h7FFF}, 4'b0001);
    chk("pre_rst_sticky", bus.sticky_ovf_o[0], 1);
    rdy_mode = 3;
    tick(2);
    send({96'h0, 32'h00050000}, 2'b00, 1'b1, w);
    send({96'h0, 32'h00060000}, 2'b00, 1'b1, w);
    chk("full_ready_lo", bus.ready_o, 0);
    chk("full_valid_o", bus.valid_o, 1);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    chk("mid_rst_valid_o", bus.valid_o, 0);
    chk("mid_rst_sticky", bus.sticky_ovf_o, 0);
    chk("mid_rst_data_o", bus.data_o, 0);
    chk("mid_rst_ovf_o", bus.ovf_o, 0);
    rdy_mode = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("post_rst_no_stale", bus.valid_o, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fixedpoint_formatter_pipe.md
Name: fixedpoint_formatter_pipe

Overview:
Parametrised, pipelined, multi-lane successor to the combinational fixed-point formatter. It converts LANES signed two's-complement words of IN_W bits to OUT_W bits. Per beat it drops SHIFT fractional LSBs using a selectable rounding mode, saturates to the OUT_W range, and reports overflow per lane. It sits between the wide MAC/accumulator output and the 16-bit result buffer, with a valid/ready handshake on both sides.

Parameters:
IN_W, 32, input word width per lane (signed)
OUT_W, 16, output word width per lane (signed)
SHIFT, 16, fractional LSBs dropped; legal range 1..IN_W-OUT_W
LANES, 4, independent lanes processed in parallel per beat

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
valid_i  input  1  input beat valid
ready_o  output  1  block can accept a beat this cycle
data_i  input  LANES*IN_W  lane k at bits [k*IN_W +: IN_W]
mode_i  input  2  rounding mode for this beat: 00 truncate(floor), 01 round-half-up, 10 round-half-even, 11 reserved (treated as 00)
sat_en_i  input  1  1 = saturate on overflow; 0 = wrap (keep low OUT_W bits)
valid_o  output  1  output beat valid
ready_i  input  1  downstream accepts output
data_o  output  LANES*OUT_W  lane k at bits [k*OUT_W +: OUT_W]
ovf_o  output  LANES  per-lane overflow for the current output beat
sticky_ovf_o  output  LANES  per-lane sticky overflow since last clear
clr_i  input  1  clears sticky_ovf_o

Behaviour:
- Reset (rst_i sampled high at a clk_i edge): valid_o=0, data_o=0, ovf_o=0, sticky_ovf_o=0. Both pipeline stages are emptied, and any in-flight beat is discarded. ready_o=1 in the first cycle after reset.
- Transfer occurs when valid_i&ready_o (input side) or valid_o&ready_i (output side). mode_i and sat_en_i are sampled with data_i on the input transfer and travel with the beat.
- Two register stages. Latency is 2 cycles from input transfer to valid_o with no backpressure. Throughput is 1 beat/cycle.
- Stage 1 rounding, per lane. q = x >>> SHIFT (arithmetic), f = x[SHIFT-1:0], half = 1<<(SHIFT-1).
  - Truncate: r = q.
  - Half-up: r = q + (f >= half).
  - Half-even: r = q + ((f > half) | (f == half & q[0])).
  - r is held at IN_W-SHIFT+1 bits, so the increment cannot wrap.
- Stage 2 range check, per lane. Overflow when r > 2^(OUT_W-1)-1 or r < -2^(OUT_W-1).
  - With sat_en: output clamps to 0x7FFF / 0x8000 (OUT_W=16).
  - Without sat_en: output is r[OUT_W-1:0].
  - ovf_o[k] is set in either case.
- Stall: en2 = ~valid_o | ready_i; en1 = ~s1_valid | en2; ready_o = en1, combinational from ready_i.
  - While valid_o & ~ready_i, data_o and ovf_o hold stable.
  - No beat is dropped or duplicated.
- sticky_ovf_o[k] sets on an output transfer whose ovf_o[k]=1, and clears on clr_i. If clear and set happen in the same cycle, set wins.
- Lanes are fully independent; only the handshake is shared.

Test Plan:
- LANES=1, lane0=32'd17030722 (0x0103DE42): mode 00 -> 0x0103; mode 01 -> 0x0104; mode 10 -> 0x0104. ovf_o=0 in all modes, latency 2.
- Ties: 0x00028000 (2.5) -> half-up 0x0003, half-even 0x0002. 0xFFFF8000 (-0.5) -> truncate 0xFFFF, half-up 0x0000, half-even 0x0000.
- Overflow: 0x7FFF8000 with mode 01 -> sat_en=1 gives 0x7FFF and ovf_o=1; sat_en=0 gives 0x8000 and ovf_o=1. 0x80000000 with sat_en=1 gives 0x8000 and ovf_o=0. sticky_ovf_o=1 persists until clr_i; clr_i in the same cycle as a new overflow transfer leaves it at 1.
- Backpressure: stream 8 beats of incrementing data with ready_i toggling 1,0,0,1,... -> all 8 beats appear in order, and data_o is stable during stalls. ready_o drops only while both stages are full and ready_i=0.
- LANES=4, mixed lanes {17030722, 0x7FFF8000, 0xFFFF8000, 0} with mode 01 and sat_en=1 -> {0x0104, 0x7FFF, 0x0000, 0x0000}, ovf_o=4'b0010.
- Reset mid-stream: assert rst_i with both stages full -> the next cycle has valid_o=0 and sticky_ovf_o=0; no stale beat is emitted after reset releases.
